// File: rtl/step_ctrl_pkg.sv
// Shared types and default timing constants for the CPU step/run clock-enable controller.
package step_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } ctrl_state_t;

    // 10 ms debounce and 2 Hz run rate at a 50 MHz board clock
    localparam int unsigned DEFAULT_DEBOUNCE_CYCLES = 500000;
    localparam int unsigned DEFAULT_RUN_DIV         = 25000000;

endpackage

// File: rtl/cpu_step_ctrl_debounce.sv
// Two-flop synchronizer followed by a stable-count debouncer for one raw board input.
module debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter logic        RESET_LEVEL     = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic level
);

    localparam int unsigned CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1;
    logic          sync2;
    logic [CW-1:0] cnt;

    // Sync flops reset to the inactive level so an input already active at reset
    // release is seen as a fresh transition.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= RESET_LEVEL;
            sync2 <= RESET_LEVEL;
            level <= RESET_LEVEL;
            cnt   <= '0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            if (sync2 == level) begin
                cnt <= '0;
            end else if (cnt == CNT_MAX) begin
                level <= sync2;
                cnt   <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/cpu_step_ctrl.sv
// Clock-enable controller for the single-cycle core: single-step on button press,
// free-run at a divided rate, stop on halt, and count issued enables.
module cpu_step_ctrl
    import step_ctrl_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int unsigned RUN_DIV         = DEFAULT_RUN_DIV,
    parameter int unsigned CNT_W           = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             step_btn_n,
    input  logic             run_sw,
    input  logic             halt,
    output logic             cpu_en,
    output logic             running,
    output logic [CNT_W-1:0] cycle_count
);

    localparam int unsigned DIV_W = $clog2(RUN_DIV);
    localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(RUN_DIV - 1);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
    endfunction

    logic             btn_level;
    logic             btn_prev;
    logic             run_level;
    logic             step_req;
    ctrl_state_t      state;
    logic [DIV_W-1:0] div;

    debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .RESET_LEVEL     (1'b1)
    ) u_btn_db (
        .clk   (clk),
        .rst_n (rst_n),
        .raw   (step_btn_n),
        .level (btn_level)
    );

    debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .RESET_LEVEL     (1'b0)
    ) u_run_db (
        .clk   (clk),
        .rst_n (rst_n),
        .raw   (run_sw),
        .level (run_level)
    );

    // Press edge of the accepted (active-low) button level; release is ignored.
    assign step_req = btn_prev & ~btn_level;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            div         <= '0;
            cpu_en      <= 1'b0;
            running     <= 1'b0;
            btn_prev    <= 1'b1;
            cycle_count <= '0;
        end else begin
            cpu_en   <= 1'b0;
            btn_prev <= btn_level;
            if (cpu_en) begin
                cycle_count <= sat_inc(cycle_count);
            end

            // Halt overrides any step request or terminal count in the same cycle.
            if (halt) begin
                state   <= HALT;
                running <= 1'b0;
                div     <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        if (step_req) begin
                            cpu_en <= 1'b1;
                        end
                        if (run_level) begin
                            state   <= RUN;
                            running <= 1'b1;
                            div     <= '0;
                        end
                    end
                    RUN: begin
                        if (!run_level) begin
                            state   <= IDLE;
                            running <= 1'b0;
                            div     <= '0;
                        end else if (div == DIV_MAX) begin
                            cpu_en <= 1'b1;
                            div    <= '0;
                        end else begin
                            div <= div + DIV_W'(1);
                        end
                    end
                    HALT: begin
                        state   <= IDLE;
                        running <= 1'b0;
                        div     <= '0;
                    end
                    default: begin
                        state   <= IDLE;
                        running <= 1'b0;
                        div     <= '0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_cpu_step_ctrl.sv
// Directed bench for cpu_step_ctrl with DEBOUNCE_CYCLES=4, RUN_DIV=5, CNT_W=8.
module tb_cpu_step_ctrl;
    import step_ctrl_pkg::*;

    logic       clk;
    logic       rst_n;
    logic       step_btn_n;
    logic       run_sw;
    logic       halt;
    logic       cpu_en;
    logic       running;
    logic [7:0] cycle_count;

    int checks;
    int passed;
    int edge_n;
    int pulses;
    int first_pulse;
    int last_pulse;
    int consec;
    bit prev_en;

    cpu_step_ctrl #(
        .DEBOUNCE_CYCLES (4),
        .RUN_DIV         (5),
        .CNT_W           (8)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .step_btn_n  (step_btn_n),
        .run_sw      (run_sw),
        .halt        (halt),
        .cpu_en      (cpu_en),
        .running     (running),
        .cycle_count (cycle_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic clr_log();
        edge_n      = 0;
        pulses      = 0;
        first_pulse = 0;
        last_pulse  = 0;
        prev_en     = 1'b0;
    endtask

    // Advance one clock and record enable pulses by edge number.
    task automatic adv();
        @(posedge clk);
        #1;
        edge_n++;
        if (cpu_en === 1'b1) begin
            if (prev_en) consec++;
            pulses++;
            if (first_pulse == 0) first_pulse = edge_n;
            last_pulse = edge_n;
        end
        prev_en = (cpu_en === 1'b1);
    endtask

    task automatic do_reset();
        rst_n      = 1'b0;
        step_btn_n = 1'b1;
        run_sw     = 1'b0;
        halt       = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        clr_log();
    endtask

    task automatic test_reset();
        rst_n      = 1'b0;
        step_btn_n = 1'b1;
        run_sw     = 1'b0;
        halt       = 1'b0;
        @(posedge clk);
        #1;
        checks++; if (cpu_en !== 1'b0) $display("FAIL reset_cpu_en: got %b want 0", cpu_en); else passed++;
        checks++; if (running !== 1'b0) $display("FAIL reset_running: got %b want 0", running); else passed++;
        checks++; if (cycle_count !== 8'd0) $display("FAIL reset_count: got %0d want 0", cycle_count); else passed++;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        clr_log();
    endtask

    task automatic test_clean_press();
        do_reset();
        step_btn_n = 1'b0;
        repeat (20) adv();
        checks++; if (first_pulse != 7) $display("FAIL press_edge: got %0d want 7", first_pulse); else passed++;
        checks++; if (pulses != 1) $display("FAIL press_pulses: got %0d want 1", pulses); else passed++;
        checks++; if (cycle_count !== 8'd1) $display("FAIL press_count: got %0d want 1", cycle_count); else passed++;
        step_btn_n = 1'b1;
        clr_log();
        repeat (15) adv();
        checks++; if (pulses != 0) $display("FAIL release_pulses: got %0d want 0", pulses); else passed++;
        checks++; if (cycle_count !== 8'd1) $display("FAIL release_count: got %0d want 1", cycle_count); else passed++;
    endtask

    task automatic test_bounce();
        do_reset();
        for (int i = 0; i < 16; i++) begin
            step_btn_n = (i % 4) >= 2;
            adv();
        end
        step_btn_n = 1'b1;
        repeat (12) adv();
        checks++; if (pulses != 0) $display("FAIL bounce_pulses: got %0d want 0", pulses); else passed++;
        checks++; if (cycle_count !== 8'd0) $display("FAIL bounce_count: got %0d want 0", cycle_count); else passed++;
    endtask

    task automatic test_btn_held_reset();
        rst_n      = 1'b0;
        step_btn_n = 1'b0;
        run_sw     = 1'b0;
        halt       = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        clr_log();
        repeat (20) adv();
        checks++; if (first_pulse != 7) $display("FAIL held_edge: got %0d want 7", first_pulse); else passed++;
        checks++; if (pulses != 1) $display("FAIL held_pulses: got %0d want 1", pulses); else passed++;
        step_btn_n = 1'b1;
        repeat (10) adv();
    endtask

    task automatic test_run_mode();
        do_reset();
        run_sw = 1'b1;
        repeat (6) adv();
        checks++; if (running !== 1'b0) $display("FAIL run_early: got %b want 0", running); else passed++;
        adv();
        checks++; if (running !== 1'b1) $display("FAIL run_entry: got %b want 1", running); else passed++;
        repeat (7) adv();
        step_btn_n = 1'b0;
        repeat (10) adv();
        step_btn_n = 1'b1;
        repeat (16) adv();
        checks++; if (pulses != 6) $display("FAIL run_pulses: got %0d want 6", pulses); else passed++;
        checks++; if (first_pulse != 12) $display("FAIL run_first: got %0d want 12", first_pulse); else passed++;
        checks++; if (last_pulse != 37) $display("FAIL run_last: got %0d want 37", last_pulse); else passed++;
        checks++; if (cycle_count !== 8'd6) $display("FAIL run_count: got %0d want 6", cycle_count); else passed++;
        run_sw = 1'b0;
        clr_log();
        repeat (20) adv();
        checks++; if (pulses != 1) $display("FAIL stop_pulses: got %0d want 1", pulses); else passed++;
        checks++; if (last_pulse != 2) $display("FAIL stop_last: got %0d want 2", last_pulse); else passed++;
        checks++; if (running !== 1'b0) $display("FAIL stop_running: got %b want 0", running); else passed++;
        checks++; if (cycle_count !== 8'd7) $display("FAIL stop_count: got %0d want 7", cycle_count); else passed++;
    endtask

    task automatic test_halt_priority();
        do_reset();
        run_sw = 1'b1;
        repeat (11) adv();
        halt = 1'b1;
        adv();
        checks++; if (cpu_en !== 1'b0) $display("FAIL halt_en: got %b want 0", cpu_en); else passed++;
        checks++; if (running !== 1'b0) $display("FAIL halt_running: got %b want 0", running); else passed++;
        checks++; if (dut.state !== HALT) $display("FAIL halt_state: got %0d want %0d", dut.state, HALT); else passed++;
        repeat (3) adv();
        halt = 1'b0;
        adv();
        checks++; if (dut.state !== IDLE) $display("FAIL unhalt_state: got %0d want %0d", dut.state, IDLE); else passed++;
        adv();
        checks++; if (running !== 1'b1) $display("FAIL rerun_running: got %b want 1", running); else passed++;
        repeat (5) adv();
        checks++; if (cpu_en !== 1'b1) $display("FAIL rerun_en: got %b want 1", cpu_en); else passed++;
        checks++; if (pulses != 1) $display("FAIL halt_pulses: got %0d want 1", pulses); else passed++;
        checks++; if (cycle_count !== 8'd0) $display("FAIL halt_count: got %0d want 0", cycle_count); else passed++;
        run_sw = 1'b0;
        repeat (10) adv();
    endtask

    task automatic test_saturation();
        do_reset();
        for (int i = 0; i < 300; i++) begin
            step_btn_n = 1'b0;
            repeat (8) adv();
            step_btn_n = 1'b1;
            repeat (8) adv();
            if (i == 254) begin
                checks++; if (cycle_count !== 8'd255) $display("FAIL sat_reach: got %0d want 255", cycle_count); else passed++;
            end
        end
        checks++; if (cycle_count !== 8'd255) $display("FAIL sat_hold: got %0d want 255", cycle_count); else passed++;
        checks++; if (pulses != 300) $display("FAIL sat_pulses: got %0d want 300", pulses); else passed++;
    endtask

    task automatic test_reset_mid();
        do_reset();
        run_sw = 1'b1;
        repeat (15) adv();
        checks++; if (cycle_count !== 8'd1) $display("FAIL mid_pre_count: got %0d want 1", cycle_count); else passed++;
        rst_n = 1'b0;
        #1;
        checks++; if (cpu_en !== 1'b0) $display("FAIL mid_en: got %b want 0", cpu_en); else passed++;
        checks++; if (running !== 1'b0) $display("FAIL mid_running: got %b want 0", running); else passed++;
        checks++; if (cycle_count !== 8'd0) $display("FAIL mid_count: got %0d want 0", cycle_count); else passed++;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        clr_log();
        repeat (7) adv();
        checks++; if (running !== 1'b1) $display("FAIL mid_rerun: got %b want 1", running); else passed++;
        repeat (5) adv();
        checks++; if (first_pulse != 12) $display("FAIL mid_first: got %0d want 12", first_pulse); else passed++;
        checks++; if (pulses != 1) $display("FAIL mid_pulses: got %0d want 1", pulses); else passed++;
        run_sw = 1'b0;
        repeat (10) adv();
    endtask

    task automatic test_back_to_back();
        checks++; if (consec != 0) $display("FAIL back_to_back: got %0d want 0", consec); else passed++;
    endtask

    initial begin
        checks = 0;
        passed = 0;
        consec = 0;
        clr_log();
        test_reset();
        test_clean_press();
        test_bounce();
        test_btn_held_reset();
        test_run_mode();
        test_halt_priority();
        test_saturation();
        test_reset_mid();
        test_back_to_back();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
